pipelined_ram_master: RTL and testbench

- Request-side controller for the pipelined distributed RAM (synchronous write; 2-cycle read through an internal pipe register).
- Accepts client commands over a valid/ready handshake: single write, single read, burst read, fill.
- Drives the RAM's we/addr/DI pins and tracks read latency, so the client receives qualified read data with rd_valid instead of raw DO.

---
 rtl/pipelined_ram_pkg.sv | 31 +++
 rtl/ram_rd_tracker.sv | 38 +++
 rtl/pipelined_ram_master.sv | 134 +++++++++++++
 tb/tb_pipelined_ram_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ram_pkg.sv
// Shared encodings and defaults for the pipelined RAM master.
// No logic; constants only.
// No handshake.
package pipelined_ram_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        OP_WR    = 2'b00,
        OP_RD    = 2'b01,
        OP_BURST = 2'b10,
        OP_FILL  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_WR) || (op == OP_FILL);
    endfunction

    function automatic logic op_is_single(input logic [1:0] op);
        return (op == OP_WR) || (op == OP_RD);
    endfunction

endpackage

// File: rtl/ram_rd_tracker.sv
// Valid/address shift register that follows reads through the RAM pipe.
// Latency DEPTH cycles from push to out; synchronous clear.
// No backpressure: one push per cycle, always advances.
module ram_rd_tracker #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push_vld,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= push_vld;
            addr_q[0] <= push_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/pipelined_ram_master.sv
// Command front-end for the pipelined RAM: single/burst reads, writes, fills.
// One RAM access per cycle from the cycle after accept; read data RD_LAT cycles later.
// cmd_ready only in IDLE; no backpressure on read data.
module pipelined_ram_master
    import pipelined_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = RAM_RD_LAT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done
);

    localparam int DW = $clog2(RD_LAT + 1);

    state_t            state, state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] data_q;
    logic [DW-1:0]     drain_q;
    logic              issue_rd;
    logic              trk_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RST gates the strobes so an aborted command cannot write or report in its last cycle.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        ram_we    = 1'b0;
        done      = 1'b0;
        issue_rd  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !RST;
                if (cmd_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we   = wr_q && !RST;
                issue_rd = !wr_q;
                if (count_q == '0) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    done      = !RST;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wr_q    <= op_is_write(cmd_op);
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        count_q <= op_is_single(cmd_op) ? '0 : cmd_len;
                    end
                end
                ST_RUN: begin
                    addr_q <= addr_q + 1'b1;
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end else begin
                        // Reads wait for the last word to leave the RAM pipe.
                        drain_q <= wr_q ? '0 : DW'(RD_LAT - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q != '0) begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ram_rd_tracker #(
        .DEPTH  (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_trk (
        .clk       (CLK),
        .clr       (RST),
        .push_vld  (issue_rd),
        .push_addr (addr_q),
        .out_vld   (trk_vld),
        .out_addr  (rd_addr)
    );

    assign ram_addr = addr_q;
    assign ram_di   = data_q;
    assign rd_valid = trk_vld && !RST;
    assign rd_data  = ram_do;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pipelined_ram_master.sv
// Self-checking bench for pipelined_ram_master with a behavioural RAM and
// a per-command timing/data model computed from command parameters.
module tb_pipelined_ram_master;
    import pipelined_ram_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [8:0] cmd_addr;
    logic [8:0] cmd_len;
    logic [3:0] cmd_data;
    logic       ram_we;
    logic [8:0] ram_addr;
    logic [3:0] ram_di;
    logic [3:0] ram_do;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [8:0] rd_addr;
    logic       busy;
    logic       done;

    int total  = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    pipelined_ram_master dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
        .busy(busy), .done(done)
    );

    // Behavioural pipelined RAM: pipe register holds during writes, DO follows pipe.
    logic [3:0] mem [512];
    logic [3:0] pipe_q, do_q;
    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        else        pipe_q <= mem[ram_addr];
        do_q <= pipe_q;
    end
    assign ram_do = do_q;

    logic [3:0] exp_mem [512];

    function automatic logic [8:0] addr_at(input logic [8:0] a, input int off);
        return 9'((int'(a) + off) % 512);
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    task automatic wait_accept(output int waited);
        bit ok = 0;
        waited = 0;
        while (!ok && waited < 20) begin
            @(negedge CLK);
            if (cmd_ready && cmd_valid) ok = 1;
            else waited++;
        end
        chk("accept_seen", int'(ok), 1);
        @(posedge CLK); #1;
    endtask

    // Called in the first cycle after acceptance; checks every cycle up to done.
    task automatic check_cmd(input logic [1:0] op, input logic [8:0] a, input logic [8:0] len,
                             input logic [3:0] d, output int words, output int done_at,
                             output logic [3:0] first);
        int  n    = op_is_single(op) ? 1 : int'(len) + 1;
        bit  wr   = op_is_write(op);
        int  last = wr ? n + 1 : n + 2;
        bit  exp_rv;
        words = 0; done_at = -1; first = 4'h0;
        for (int k = 1; k <= last; k++) begin
            @(negedge CLK);
            chk("busy", int'(busy), 1);
            chk("cmd_ready_busy", int'(cmd_ready), 0);
            if (k <= n) begin
                chk("ram_we", int'(ram_we), int'(wr));
                chk("ram_addr", int'(ram_addr), int'(addr_at(a, k - 1)));
                if (wr) begin
                    chk("ram_di", int'(ram_di), int'(d));
                    exp_mem[addr_at(a, k - 1)] = d;
                end
            end else begin
                chk("ram_we_drain", int'(ram_we), 0);
            end
            exp_rv = !wr && k >= 3 && (k - 3) < n;
            chk("rd_valid", int'(rd_valid), int'(exp_rv));
            if (rd_valid) begin
                if (words == 0) first = rd_data;
                words++;
            end
            if (exp_rv && rd_valid) begin
                chk("rd_addr", int'(rd_addr), int'(addr_at(a, k - 3)));
                chk("rd_data", int'(rd_data), int'(exp_mem[addr_at(a, k - 3)]));
            end
            chk("done", int'(done), int'(k == last));
            if (done) done_at = k;
            @(posedge CLK); #1;
        end
    endtask

    task automatic idle_check();
        @(negedge CLK);
        chk("idle_busy", int'(busy), 0);
        chk("idle_cmd_ready", int'(cmd_ready), 1);
        chk("idle_rd_valid", int'(rd_valid), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_ram_we", int'(ram_we), 0);
        @(posedge CLK); #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [8:0] a, input logic [8:0] len,
                         input logic [3:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len; cmd_data = d;
    endtask

    task automatic send(input logic [1:0] op, input logic [8:0] a, input logic [8:0] len,
                        input logic [3:0] d, output int words, output int done_at,
                        output logic [3:0] first);
        int w;
        drive(op, a, len, d);
        wait_accept(w);
        cmd_valid = 1'b0;
        check_cmd(op, a, len, d, words, done_at, first);
        idle_check();
    endtask

    typedef struct {
        logic [1:0] op;
        logic [8:0] addr;
        logic [8:0] len;
        logic [3:0] data;
        int         words;
        int         done_k;
        logic [3:0] rd_exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int w, dn, wt;
        logic [3:0] fd;
        logic [1:0] aop;

        vecs[0] = '{OP_WR,    9'h005, 9'd0,   4'hA, 1,   2,   4'h0};
        vecs[1] = '{OP_RD,    9'h005, 9'd0,   4'h0, 1,   3,   4'hA};
        vecs[2] = '{OP_FILL,  9'h1FE, 9'd3,   4'h7, 4,   5,   4'h0};
        vecs[3] = '{OP_BURST, 9'h1FE, 9'd3,   4'h0, 4,   6,   4'h7};
        vecs[4] = '{OP_FILL,  9'h000, 9'd511, 4'h3, 512, 513, 4'h0};
        vecs[5] = '{OP_BURST, 9'h000, 9'd511, 4'h0, 512, 514, 4'h3};
        vecs[6] = '{OP_WR,    9'h010, 9'h055, 4'hC, 1,   2,   4'h0};
        vecs[7] = '{OP_RD,    9'h010, 9'h1AA, 4'h0, 1,   3,   4'hC};

        RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_addr = '0; cmd_len = '0; cmd_data = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_di", int'(ram_di), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle_check();

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data, w, dn, fd);
            chk("vec_words", w, op_is_write(vecs[i].op) ? 0 : vecs[i].words);
            chk("vec_done_cycle", dn, vecs[i].done_k);
            if (!op_is_write(vecs[i].op)) chk("vec_rd_first", int'(fd), int'(vecs[i].rd_exp));
        end

        // Command held valid through a busy period with different fields.
        drive(OP_BURST, 9'h1FE, 9'd3, 4'h0);
        wait_accept(wt);
        drive(OP_WR, 9'h040, 9'd0, 4'h9);
        check_cmd(OP_BURST, 9'h1FE, 9'd3, 4'h0, w, dn, fd);
        chk("held_words", w, 4);
        wait_accept(wt);
        chk("held_accept_delay", wt, 0);
        cmd_valid = 1'b0;
        check_cmd(OP_WR, 9'h040, 9'd0, 4'h9, w, dn, fd);
        idle_check();
        send(OP_RD, 9'h040, 9'd0, 4'h0, w, dn, fd);
        chk("held_readback", int'(fd), 9);

        // Reset asserted in the third RUN cycle of a len=7 command.
        for (int j = 0; j < 2; j++) begin
            aop = (j == 0) ? OP_BURST : OP_FILL;
            drive(aop, 9'h100, 9'd7, 4'h5);
            wait_accept(wt);
            cmd_valid = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                @(negedge CLK);
                chk("abort_ram_addr", int'(ram_addr), int'(addr_at(9'h100, k - 1)));
                chk("abort_ram_we", int'(ram_we), int'(op_is_write(aop)));
                if (op_is_write(aop)) exp_mem[addr_at(9'h100, k - 1)] = 4'h5;
                @(posedge CLK); #1;
            end
            RST = 1'b1;
            @(negedge CLK);
            chk("abort_rst_we", int'(ram_we), 0);
            chk("abort_rst_rd_valid", int'(rd_valid), 0);
            chk("abort_rst_done", int'(done), 0);
            chk("abort_rst_cmd_ready", int'(cmd_ready), 0);
            @(posedge CLK); #1;
            RST = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge CLK);
                chk("post_abort_rd_valid", int'(rd_valid), 0);
                chk("post_abort_done", int'(done), 0);
                chk("post_abort_ram_we", int'(ram_we), 0);
                chk("post_abort_busy", int'(busy), 0);
                chk("post_abort_cmd_ready", int'(cmd_ready), 1);
                @(posedge CLK); #1;
            end
        end
        send(OP_BURST, 9'h100, 9'd3, 4'h0, w, dn, fd);
        chk("abort_readback_words", w, 4);

        // Randomised commands against the model memory.
        for (int r = 0; r < 40; r++) begin
            aop = 2'($urandom_range(0, 3));
            send(aop, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), w, dn, fd);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, total);
        $fatal(1, "timeout");
    end

endmodule
